// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the PC register and the instruction-memory fetch port.
// Keeps one fetch outstanding, holds one fetched instruction for decode,
// arbitrates redirects (trap > branch > jal) and drops fetches that a redirect
// has made stale.
// Optional build macro: FETCH_CTRL_PERF_EN adds saturating performance counters.
module fetch_ctrl #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            JUMP,
    output logic [XLEN-1:0] JUMP_PC,
    output logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [ILEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    input  logic            hazard_stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_pc,
    output logic            flush
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_redirect_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [ILEN-1:0] if_inst_q, if_inst_d;
    logic            if_valid_q, if_valid_d;
    logic            redirect;
    logic            can_accept;
    logic            complete;

    // Redirect arbitration; JUMP/flush are masked in reset so nothing leaks out
    always_comb begin
        redirect   = trap_valid | br_valid | jal_valid;
        can_accept = (!if_valid_q || id_ready) && !hazard_stall;
        JUMP       = redirect & rst_n;
        flush      = redirect & rst_n;
        if (trap_valid)     JUMP_PC = trap_pc;
        else if (br_valid)  JUMP_PC = br_pc;
        else if (jal_valid) JUMP_PC = jal_pc;
        else                JUMP_PC = '0;
    end

    // Fetch FSM: request generation and completion detection
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        imem_req   = 1'b0;
        imem_addr  = req_addr_q;
        complete   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (!redirect && can_accept) begin
                    imem_req   = 1'b1;
                    imem_addr  = pc_in;
                    req_addr_d = pc_in;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // A response arriving with the redirect is consumed and dropped
                    state_d = imem_ready ? ST_IDLE : ST_DRAIN;
                end else if (imem_ready && can_accept) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Decode buffer next state: redirect clears, completion refills, id_ready consumes
    always_comb begin
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        if (redirect) begin
            if_valid_d = 1'b0;
        end else if (complete) begin
            if_valid_d = 1'b1;
            if_inst_d  = imem_rdata;
            if_pc_d    = req_addr_q;
        end else if (id_ready) begin
            if_valid_d = 1'b0;
        end
        stall = ~complete;
    end

    // State and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            req_addr_q <= '0;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign if_pc    = if_pc_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [63:0] perf_fetch_q, perf_redirect_q, perf_stall_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q    <= '0;
            perf_redirect_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (complete && perf_fetch_q != '1)
                perf_fetch_q <= perf_fetch_q + 64'd1;
            if (JUMP && perf_redirect_q != '1)
                perf_redirect_q <= perf_redirect_q + 64'd1;
            if (stall && !JUMP && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 64'd1;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_stall_cnt    = perf_stall_q;
`else
    // Counters not built in this configuration
`endif

endmodule
